fft_nlp_arbiter: RTL
====================

FFT_NLP_ARBITER -- requirements
Module: fft_nlp_arbiter

Interface
REQ-001 SHALL have parameter N, default 80: datapath word width in bits, matching the FFT engine.
REQ-002 SHALL have parameter TIMEOUT, default 100000: maximum number of WAIT cycles before a job is aborted.
REQ-003 SHALL have parameter CW, default 17: width of the watchdog counter; requires 2^CW > TIMEOUT.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; the ports are named as the codebase names them:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active low
REQ-005 req0, req1  in  1 each  level job request from requester 0 and requester 1; held high until the matching done pulse.
REQ-006 grant0, grant1  out  1 each  requester currently owns the FFT engine.
REQ-007 done0, done1  out  1 each  one-cycle job-complete pulse to the owning requester.
REQ-008 startfft  out  1  one-cycle start pulse to the FFT engine.
REQ-009 donefft  in  1  completion strobe from the FFT engine.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 timeout_err  out  1  sticky flag: the last job was aborted by the watchdog.
REQ-012 eng_addr_real, eng_addr_imag  in  9 each  engine input-RAM read addresses; broadcast unchanged to both requesters' input RAMs.
REQ-013 req0_real, req0_imag, req1_real, req1_imag  in  N each  read data from each requester's input RAM.
REQ-014 eng_in_real, eng_in_imag  out  N each  muxed read data returned to the engine.
REQ-015 eng_wr_addr  in  9  engine result address.
REQ-016 eng_wr_real, eng_wr_imag  in  N each  engine result data; broadcast to both requesters.
REQ-017 wr_en0, wr_en1  out  1 each  result write enable, one per requester.

Function
REQ-018 SHALL implement the states IDLE, START, WAIT and RELEASE.
REQ-019 IDLE -> START when req0 or req1 is high; IDLE holds otherwise.
- Owner selection: if only one request is high, that requester wins.
- If both are high, the winner is the requester that is not last_owner (round-robin).
- owner and last_owner are registered in IDLE.
REQ-020 START: startfft = 1 and grant[owner] = 1 for exactly one cycle; clears the watchdog counter to 0; next state is WAIT.
REQ-021 WAIT:
- grant[owner] = 1 and wr_en[owner] = 1; the other grant and write enable are 0.
- The watchdog counter increments by 1 each cycle.
- Exit to RELEASE on the first cycle donefft = 1, or when the counter equals TIMEOUT-1.
REQ-022 Timeout: on the TIMEOUT exit, timeout_err is set to 1.
- If donefft = 1 in that same cycle, completion wins and timeout_err is not set.
REQ-023 RELEASE: done[owner] = 1 for one cycle; the grant stays high during this cycle; next state is IDLE.
- Both grants drop on the cycle after RELEASE.
REQ-024 timeout_err is cleared in START of the next job.
REQ-025 Read-data mux: eng_in_real/eng_in_imag = req[owner]_real/imag, purely combinational on the registered owner; there is no added read latency.
REQ-026 The owner SHALL NOT change between START and RELEASE inclusive; request changes during that window are ignored.
REQ-027 A requester dropping its req mid-job does not abort the job; the done pulse is still issued.
REQ-028 donefft = 1 in IDLE or START SHALL be ignored.
REQ-029 At most one of grant0/grant1, and at most one of wr_en0/wr_en1, is ever high.
REQ-030 After RELEASE, the arbiter returns to IDLE for at least one cycle before any new START; back-to-back jobs therefore have 1 idle cycle.

Reset
REQ-031 On rst low, asynchronously: state = IDLE.
- grant0, grant1, done0, done1, startfft, wr_en0, wr_en1, busy and timeout_err all = 0.
- The watchdog counter = 0.
- owner = 0 and last_owner = 1, so requester 0 wins the first tie.
REQ-032 Reset asserted mid-job SHALL abandon the job with no done pulse.
- The arbiter leaves IDLE no earlier than the first clock after rst deasserts.

Verification
REQ-033 After reset, req0 = 1 and req1 = 0 -> startfft pulses 2 cycles later; grant0 = 1 from START.
- Inject donefft 62000 cycles later -> done0 pulses the next cycle; grant0 = 0 one cycle after that.
REQ-034 req0 = req1 = 1 continuously -> grants alternate 0,1,0,1 over four jobs; done0 and done1 never overlap.
REQ-035 With TIMEOUT = 16, never assert donefft -> RELEASE after 16 WAIT cycles, done pulses, timeout_err = 1.
- timeout_err clears on the next START.
REQ-036 With TIMEOUT = 16, assert donefft on WAIT cycle 16 -> completion wins and timeout_err = 0.
REQ-037 Assert rst during WAIT with grant1 = 1 -> all outputs are 0 immediately and no done1 pulse occurs.
- With req0 high, the next job goes to requester 0.
REQ-038 Mux check: req1_real = 80'h5 and req0_real = 80'hA while owner = 1 -> eng_in_real = 80'h5.
- wr_en1 = 1 and wr_en0 = 0 throughout WAIT.

Source files
------------

// File: rtl/fft_nlp_arbiter.sv
// Two-requester arbiter for a shared FFT engine: round-robin ownership,
// per-job watchdog, read-data mux and per-owner result write enables.
module fft_nlp_arbiter #(
   parameter int unsigned N       = 80,
   parameter int unsigned TIMEOUT = 100000,
   parameter int unsigned CW      = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   output logic         grant0,
   output logic         grant1,
   output logic         done0,
   output logic         done1,
   output logic         startfft,
   input  logic         donefft,
   output logic         busy,
   output logic         timeout_err,
   input  logic [8:0]   eng_addr_real,
   input  logic [8:0]   eng_addr_imag,
   input  logic [N-1:0] req0_real,
   input  logic [N-1:0] req0_imag,
   input  logic [N-1:0] req1_real,
   input  logic [N-1:0] req1_imag,
   output logic [N-1:0] eng_in_real,
   output logic [N-1:0] eng_in_imag,
   input  logic [8:0]   eng_wr_addr,
   input  logic [N-1:0] eng_wr_real,
   input  logic [N-1:0] eng_wr_imag,
   output logic         wr_en0,
   output logic         wr_en1,
   output logic [8:0]   ram_addr_real,
   output logic [8:0]   ram_addr_imag,
   output logic [8:0]   ram_wr_addr,
   output logic [N-1:0] ram_wr_real,
   output logic [N-1:0] ram_wr_imag
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic          owner;
   logic          last_owner;
   logic          win;
   logic [CW-1:0] wdog;

   // On a tie the requester that did not own the previous job wins.
   always_comb begin
      win = req1;
      if (req0 && req1)
         win = ~last_owner;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         wdog        <= '0;
         grant0      <= 1'b0;
         grant1      <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         startfft    <= 1'b0;
         wr_en0      <= 1'b0;
         wr_en1      <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               grant0 <= 1'b0;
               grant1 <= 1'b0;
               done0  <= 1'b0;
               done1  <= 1'b0;
               busy   <= 1'b0;
               if (req0 || req1) begin
                  owner       <= win;
                  last_owner  <= win;
                  startfft    <= 1'b1;
                  grant0      <= ~win;
                  grant1      <= win;
                  busy        <= 1'b1;
                  timeout_err <= 1'b0;
                  state       <= START;
               end
            end
            START: begin
               startfft <= 1'b0;
               wdog     <= '0;
               wr_en0   <= ~owner;
               wr_en1   <= owner;
               state    <= WAIT;
            end
            WAIT: begin
               // Completion on the final watchdog cycle takes priority over timeout.
               if (donefft || wdog == WD_LAST) begin
                  wr_en0 <= 1'b0;
                  wr_en1 <= 1'b0;
                  done0  <= ~owner;
                  done1  <= owner;
                  if (!donefft)
                     timeout_err <= 1'b1;
                  state <= RELEASE;
               end else begin
                  wdog <= wdog + CW'(1);
               end
            end
            RELEASE: begin
               done0  <= 1'b0;
               done1  <= 1'b0;
               grant0 <= 1'b0;
               grant1 <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign eng_in_real   = owner ? req1_real : req0_real;
   assign eng_in_imag   = owner ? req1_imag : req0_imag;
   assign ram_addr_real = eng_addr_real;
   assign ram_addr_imag = eng_addr_imag;
   assign ram_wr_addr   = eng_wr_addr;
   assign ram_wr_real   = eng_wr_real;
   assign ram_wr_imag   = eng_wr_imag;

endmodule
